// File: rtl/jpeg_zigzag_scan_if.sv
// Coefficient stream bundle for the zigzag serializer: raster-order input
// beats on one side, zigzag-order output beats on the other.
interface jpeg_zigzag_scan_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  DataInEnable;
   logic                  DataInReady;
   logic [DATA_WIDTH-1:0] DataIn;
   logic                  DataOutValid;
   logic                  DataOutReady;
   logic [DATA_WIDTH-1:0] DataOut;
   logic [5:0]            DataOutIndex;
   logic                  DataOutLast;

   // The serializer itself: consumes raster beats, produces zigzag beats.
   modport slave (
      input  DataInEnable, DataIn, DataOutReady,
      output DataInReady, DataOutValid, DataOut, DataOutIndex, DataOutLast
   );

   // The surroundings: quantizer upstream and run-length stage downstream.
   modport master (
      output DataInEnable, DataIn, DataOutReady,
      input  DataInReady, DataOutValid, DataOut, DataOutIndex, DataOutLast
   );
endinterface

// File: rtl/jpeg_zigzag_scan.sv
// Encoder-side zigzag serializer. Two 64-entry banks ping-pong: one fills in
// raster order while the other drains in zigzag order. With trailing-zero
// suppression, a block stops after its highest nonzero zigzag position.
module jpeg_zigzag_scan #(
   parameter int DATA_WIDTH          = 16,
   parameter bit SKIP_TRAILING_ZEROS = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Flush,
   jpeg_zigzag_scan_if.slave bus
);

   // Zigzag position -> raster index.
   localparam logic [5:0] ZZ [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10,
      17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34,
      27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36,
      29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46,
      53, 60, 61, 54, 47, 55, 62, 63
   };

   // Raster index -> zigzag position (inverse of ZZ).
   localparam logic [5:0] IZ [64] = '{
       0,  1,  5,  6, 14, 15, 27, 28,
       2,  4,  7, 13, 16, 26, 29, 42,
       3,  8, 12, 17, 25, 30, 41, 43,
       9, 11, 18, 24, 31, 40, 44, 53,
      10, 19, 23, 32, 39, 45, 52, 54,
      20, 22, 33, 38, 46, 51, 55, 60,
      21, 34, 37, 47, 50, 56, 59, 61,
      35, 36, 48, 49, 57, 58, 62, 63
   };

   logic [DATA_WIDTH-1:0] bank [2][64];
   logic [5:0]            wr_count;
   logic [5:0]            rd_count;
   logic                  wr_bank;
   logic                  rd_bank;
   logic [1:0]            full;
   logic [1:0]            full_nxt;
   logic [5:0]            max_zz [2];
   logic [5:0]            end_idx;
   logic                  in_ready;
   logic                  out_valid;
   logic                  out_last;
   logic                  wr_fire;
   logic                  rd_fire;

   // A bank is writable only while empty; a full bank is the one being read.
   assign in_ready  = !full[wr_bank];
   assign out_valid = full[rd_bank];
   assign end_idx   = SKIP_TRAILING_ZEROS ? max_zz[rd_bank] : 6'd63;
   assign out_last  = out_valid && (rd_count == end_idx);
   assign wr_fire   = bus.DataInEnable && in_ready;
   assign rd_fire   = out_valid && bus.DataOutReady;

   assign bus.DataInReady  = in_ready;
   assign bus.DataOutValid = out_valid;
   assign bus.DataOut      = bank[rd_bank][ZZ[rd_count]];
   assign bus.DataOutIndex = rd_count;
   assign bus.DataOutLast  = out_last;

   // Bank occupancy: a completing write and a finishing read may hit
   // different banks in the same cycle, and both must land.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
      full_nxt = full;
      if (wr_fire && wr_count == 6'd63) full_nxt[wr_bank] = 1'b1;
      if (rd_fire && out_last)          full_nxt[rd_bank] = 1'b0;
   end

   // Coefficient storage: written in raster order into the filling bank.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the banks are cleared on reset so DataOut reads 0 afterwards; Flush deliberately leaves the data alone.
      if (rst) begin
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < 64; i++)
               bank[b][i] <= '0;
      end else if (wr_fire && !Flush) begin
         bank[wr_bank][wr_count] <= bus.DataIn;
      end
   end

   // Counters, bank pointers, occupancy and last-nonzero tracking.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         wr_count  <= '0;
         rd_count  <= '0;
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         full      <= '0;
         max_zz[0] <= '0;
         max_zz[1] <= '0;
      end else if (Flush) begin
         wr_count  <= '0;
         rd_count  <= '0;
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         full      <= '0;
         max_zz[0] <= '0;
         max_zz[1] <= '0;
      end else begin
         full <= full_nxt;
         if (wr_fire) begin
            wr_count <= wr_count + 6'd1;
            if (wr_count == 6'd0)
               max_zz[wr_bank] <= '0;
            else if (bus.DataIn != '0 && IZ[wr_count] > max_zz[wr_bank])
               max_zz[wr_bank] <= IZ[wr_count];
            if (wr_count == 6'd63) wr_bank <= ~wr_bank;
         end
         if (rd_fire) begin
            if (out_last) begin
               rd_count <= '0;
               rd_bank  <= ~rd_bank;
            end else begin
               rd_count <= rd_count + 6'd1;
            end
         end
      end
   end

endmodule

// File: doc/jpeg_zigzag_scan.md
Name: jpeg_zigzag_scan

Overview:
Encoder-side zigzag serializer. It accepts 8x8 blocks of quantized coefficients serially in natural raster order (row-major, index 0..63) and emits them in JPEG zigzag order over a valid/ready stream. It is the inverse of the decoder's zigzag-to-natural register file and feeds the encoder's run-length/Huffman stage. The block is ping-pong double-buffered, so one block can be loaded while the previous one drains. Trailing zeros are optionally suppressed so the downstream stage can emit EOB.

Parameters:
DATA_WIDTH, 16, coefficient width (two's complement)
SKIP_TRAILING_ZEROS, 1, 1 = stop each block after its last nonzero zigzag position; 0 = always emit 64 beats

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
Flush  input  1  synchronous abort; discards both banks and resets counters
DataInEnable  input  1  input beat valid
DataInReady  output  1  input beat accepted when DataInEnable && DataInReady
DataIn  input  DATA_WIDTH  coefficient in raster order; the position is implicit from an internal counter
DataOutValid  output  1  output beat valid
DataOutReady  input  1  downstream accept
DataOut  output  DATA_WIDTH  coefficient in zigzag order
DataOutIndex  output  6  zigzag position of DataOut (0..63)
DataOutLast  output  1  final beat of the block

Behaviour:
- Reset (rst high, asynchronous):
  - All bank registers, WrCount, RdCount, WrBank, RdBank, Full[1:0] and MaxZz[1:0] go to 0.
  - Outputs: DataInReady=1, DataOutValid=0, DataOut=0, DataOutIndex=0, DataOutLast=0.
- Storage: two banks of 64 x DATA_WIDTH registers. Zigzag table Z[k] maps zigzag index to raster index using the standard JPEG order: 0,1,8,16,9,2,3,10,17,24,32,25,... ending ...,47,55,62,63. The inverse table IZ[r] is also built in.
- Write side:
  - DataInReady = !Full[WrBank].
  - On accept, store DataIn at raster index WrCount of bank WrBank, then increment WrCount.
  - MaxZz[WrBank] update: when WrCount==0 it loads 0. Otherwise, when DataIn != 0, it loads max(MaxZz, IZ[WrCount]).
  - When the accepted beat has WrCount==63: set Full[WrBank], toggle WrBank, and wrap WrCount to 0.
- Read side:
  - DataOutValid = Full[RdBank].
  - DataOut = bank[RdBank][Z[RdCount]], DataOutIndex = RdCount. Both are combinational from registers and stay stable while Valid && !Ready.
  - EndIdx = SKIP_TRAILING_ZEROS ? MaxZz[RdBank] : 63.
  - DataOutLast = DataOutValid && (RdCount == EndIdx).
  - On transfer (Valid && Ready): RdCount increments. If Last, clear Full[RdBank], toggle RdBank and set RdCount=0.
- Latency: DataOutValid rises in the cycle after the 64th input beat is accepted, provided that bank was empty beforehand.
- Throughput: one beat per cycle on each side, sustained.
- Index 0 (DC) is always emitted. An all-zero block yields one beat with DataOut=0 and Last=1.
- Simultaneous events:
  - A write completing bank A and a Last transfer freeing bank B in the same cycle both take effect.
  - When both banks are full, DataInReady=0 until a Last transfer. Ready returns in the following cycle.
  - A bank being read is never written.
- DataInEnable while DataInReady=0: ignored, no state change.
- Flush: a synchronous clear of counters, bank pointers, Full and MaxZz, same as reset except the data registers. Flush takes priority over a simultaneous write or read.
- Reset mid-block: the partial block is discarded and the next accepted beat is raster index 0.

Test Plan:
1. SKIP=0, DataIn=r+1 for r=0..63, DataOutReady=1 -> DataOutValid rises 1 cycle after the 64th accept. Output sequence is 1,2,9,17,10,3,4,11,...,56,63,64 with Index 0..63 and Last only at 63.
2. SKIP=1, block with raster 0 = 5 and all others zero -> a single beat with DataOut=5, Index=0, Last=1, then Valid=0.
3. SKIP=1, raster 0 = -3, raster 16 = 7 (zigzag 3), others zero -> 4 beats: -3, 0, 0, 7 with Last on Index 3. Also check: raster 63 = 1 alone gives 64 beats.
4. Three back-to-back blocks with DataOutReady held 0 -> DataInReady drops after the 128th accept. Releasing Ready drains block 1; DataInReady returns one cycle after its Last. All three blocks come out intact and in order.
5. Random DataOutReady toggling over 10 random blocks -> DataOut and Index stay stable while stalled, and the output matches a reference zigzag model with no loss or duplication.
6. rst (and, separately, Flush) asserted after 30 input beats while a block is draining -> Valid=0 and DataInReady=1 immediately. A fresh full block then emerges correctly starting at Index 0.
